// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the fetch-stage branch target predictor:
// branch type codes, counter constants and the saturating counter update.
package branch_target_predictor_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BGE      = 3'd4,
    BLTU     = 3'd5,
    BGEU     = 3'd6
  } branch_type_e;

  localparam logic [1:0] BP_CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] BP_CTR_MAX        = 2'b11;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != BP_CTR_MAX) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_target_table.sv
// Direct-mapped BTB storage: valid/tag/target/ctr per entry, two async
// read ports (fetch and EX) and one sync write port. Only valid bits reset.
module branch_target_table #(
  parameter int ENTRY_BITS = 6,
  parameter int TAG_W      = 30 - ENTRY_BITS
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [ENTRY_BITS-1:0] rd_a_idx_i,
  output logic                  rd_a_valid_o,
  output logic [TAG_W-1:0]      rd_a_tag_o,
  output logic [31:0]           rd_a_target_o,
  output logic [1:0]            rd_a_ctr_o,
  input  logic [ENTRY_BITS-1:0] rd_b_idx_i,
  output logic                  rd_b_valid_o,
  output logic [TAG_W-1:0]      rd_b_tag_o,
  output logic [31:0]           rd_b_target_o,
  output logic [1:0]            rd_b_ctr_o,
  input  logic                  wr_en_i,
  input  logic [ENTRY_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [31:0]           wr_target_i,
  input  logic [1:0]            wr_ctr_i
);

  localparam int N = 1 << ENTRY_BITS;

  logic [N-1:0]       valid_q;
  logic [TAG_W-1:0]   tag_q    [N];
  logic [31:0]        target_q [N];
  logic [1:0]         ctr_q    [N];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Payload has no reset; a cleared valid bit masks stale contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !srst_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
      ctr_q[wr_idx_i]    <= wr_ctr_i;
    end
  end

  assign rd_a_valid_o  = valid_q[rd_a_idx_i];
  assign rd_a_tag_o    = tag_q[rd_a_idx_i];
  assign rd_a_target_o = target_q[rd_a_idx_i];
  assign rd_a_ctr_o    = ctr_q[rd_a_idx_i];

  assign rd_b_valid_o  = valid_q[rd_b_idx_i];
  assign rd_b_tag_o    = tag_q[rd_b_idx_i];
  assign rd_b_target_o = target_q[rd_b_idx_i];
  assign rd_b_ctr_o    = ctr_q[rd_b_idx_i];

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-stage BTB predictor with EX-stage mispredict detection and training.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ENTRY_BITS = 6
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PCF,
  output logic [31:0] NPCPredF,
  output logic        PredTakenF,
  input  logic [31:0] PCE,
  input  logic        ValidE,
  input  logic        StallE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int TAG_W = 30 - ENTRY_BITS;

  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]      tag_f, tag_e;

  logic                  f_valid, e_valid;
  logic [TAG_W-1:0]      f_tag, e_tag;
  logic [31:0]           f_target, e_target;
  logic [1:0]            f_ctr, e_ctr;

  logic                  hit_f, hit_e, resolve;
  logic                  train_en_d;
  logic [31:0]           train_target_d;
  logic [1:0]            train_ctr_d;

  assign idx_f = PCF[ENTRY_BITS+1:2];
  assign tag_f = PCF[31:ENTRY_BITS+2];
  assign idx_e = PCE[ENTRY_BITS+1:2];
  assign tag_e = PCE[31:ENTRY_BITS+2];

  branch_target_table #(
    .ENTRY_BITS (ENTRY_BITS),
    .TAG_W      (TAG_W)
  ) u_table (
    .clk_i         (CPU_CLK),
    .srst_i        (CPU_RST),
    .rd_a_idx_i    (idx_f),
    .rd_a_valid_o  (f_valid),
    .rd_a_tag_o    (f_tag),
    .rd_a_target_o (f_target),
    .rd_a_ctr_o    (f_ctr),
    .rd_b_idx_i    (idx_e),
    .rd_b_valid_o  (e_valid),
    .rd_b_tag_o    (e_tag),
    .rd_b_target_o (e_target),
    .rd_b_ctr_o    (e_ctr),
    .wr_en_i       (train_en_d),
    .wr_idx_i      (idx_e),
    .wr_tag_i      (tag_e),
    .wr_target_i   (train_target_d),
    .wr_ctr_i      (train_ctr_d)
  );

  assign hit_f      = f_valid & (f_tag == tag_f);
  assign PredTakenF = ~CPU_RST & hit_f & f_ctr[1];
  assign NPCPredF   = PredTakenF ? f_target : PCF + 32'd4;

  // Reset suppresses resolve, so no mispredict, training or counting then.
  assign resolve     = ~CPU_RST & ValidE & ~StallE & (BranchTypeE != NOBRANCH);
  assign hit_e       = e_valid & (e_tag == tag_e);
  assign MispredictE = resolve & ((BranchE != PredTakenE) |
                                  (BranchE & (PredTargetE != BranchTargetE)));
  assign RecoverPCE  = (BranchE & ~CPU_RST) ? BranchTargetE : PCE + 32'd4;

  always_comb begin
    train_en_d     = 1'b0;
    train_target_d = e_target;
    train_ctr_d    = e_ctr;
    if (resolve) begin
      if (hit_e) begin
        train_en_d  = 1'b1;
        train_ctr_d = ctr_update(e_ctr, BranchE);
        if (BranchE) train_target_d = BranchTargetE;
      end else if (BranchE) begin
        train_en_d     = 1'b1;
        train_target_d = BranchTargetE;
        train_ctr_d    = BP_CTR_WEAK_TAKEN;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (resolve)     branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (MispredictE) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispredict_cnt_q;
`else
  assign BranchCount     = '0;
  assign MispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed test of branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;
  import branch_target_predictor_pkg::*;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic [31:0] PCF;
  logic [31:0] NPCPredF;
  logic        PredTakenF;
  logic [31:0] PCE;
  logic        ValidE;
  logic        StallE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RecoverPCE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int n_checks = 0;
  int n_fail   = 0;

  branch_target_predictor #(.ENTRY_BITS(6)) dut (
    .CPU_CLK         (CPU_CLK),
    .CPU_RST         (CPU_RST),
    .PCF             (PCF),
    .NPCPredF        (NPCPredF),
    .PredTakenF      (PredTakenF),
    .PCE             (PCE),
    .ValidE          (ValidE),
    .StallE          (StallE),
    .BranchTypeE     (BranchTypeE),
    .BranchE         (BranchE),
    .BranchTargetE   (BranchTargetE),
    .PredTakenE      (PredTakenE),
    .PredTargetE     (PredTargetE),
    .MispredictE     (MispredictE),
    .RecoverPCE      (RecoverPCE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic ex_drive(input logic [31:0] pce, input logic [2:0] btype, input logic taken,
                          input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
                          input logic stall);
    PCE = pce; BranchTypeE = btype; BranchE = taken; BranchTargetE = tgt;
    PredTakenE = ptaken; PredTargetE = ptgt; StallE = stall; ValidE = 1'b1;
    #1;
    $display("EX pc=%08h type=%0d taken=%0b tgt=%08h pred=%0b/%08h stall=%0b -> mis=%0b rec=%08h",
             pce, btype, taken, tgt, ptaken, ptgt, stall, MispredictE, RecoverPCE);
  endtask

  task automatic ex_idle();
    ValidE = 1'b0; StallE = 1'b0; BranchTypeE = NOBRANCH; BranchE = 1'b0;
  endtask

  // Drives a fetch PC and checks the combinational prediction.
  task automatic lookup(input string tag, input logic [31:0] pcf, input logic exp_taken,
                        input logic [31:0] exp_npc);
    PCF = pcf;
    #1;
    check_eq({tag, "_taken"}, {31'd0, PredTakenF}, {31'd0, exp_taken});
    check_eq({tag, "_npc"}, NPCPredF, exp_npc);
  endtask

  initial begin
    CPU_RST = 1'b1; PCF = 32'h100; PCE = 32'h200;
    ex_idle(); PredTakenE = 1'b0; PredTargetE = '0; BranchTargetE = '0;
    // A mispredicting branch during reset must be ignored.
    ex_drive(32'h200, BEQ, 1'b1, 32'h80, 1'b0, 32'h204, 1'b0);
    lookup("rst_look", 32'h100, 1'b0, 32'h104);
    check_eq("rst_mis", {31'd0, MispredictE}, 32'd0);
    check_eq("rst_rec", RecoverPCE, 32'h204);
    step(); step();
    CPU_RST = 1'b0; ex_idle();
    lookup("rst_no_train", 32'h200, 1'b0, 32'h204);
    check_eq("cold_bcnt", BranchCount, 32'd0);
    check_eq("cold_mcnt", MispredictCount, 32'd0);
    lookup("cold", 32'h100, 1'b0, 32'h104);

    // Allocate 0x100 -> 0x80; same-cycle lookup sees pre-write contents.
    ex_drive(32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
    check_eq("alloc_mis", {31'd0, MispredictE}, 32'd1);
    check_eq("alloc_rec", RecoverPCE, 32'h80);
    lookup("alloc_same", 32'h100, 1'b0, 32'h104);
    step(); ex_idle();
    lookup("alloc_next", 32'h100, 1'b1, 32'h80);

    // ctr 2 -> 3 -> 3 -> 2
    ex_drive(32'h100, BNE, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    check_eq("tk1_mis", {31'd0, MispredictE}, 32'd0);
    step();
    ex_drive(32'h100, BNE, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    step();
    ex_drive(32'h100, BNE, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
    check_eq("nt1_mis", {31'd0, MispredictE}, 32'd1);
    check_eq("nt1_rec", RecoverPCE, 32'h104);
    step(); ex_idle();
    lookup("ctr2", 32'h100, 1'b1, 32'h80);
    // ctr 2 -> 1: falls through
    ex_drive(32'h100, BNE, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
    step(); ex_idle();
    lookup("ctr1", 32'h100, 1'b0, 32'h104);
    // ctr 1 -> 2 with a new target; taken-target mismatch also mispredicts.
    ex_drive(32'h100, BLT, 1'b1, 32'h90, 1'b1, 32'h80, 1'b0);
    check_eq("tgt_mis", {31'd0, MispredictE}, 32'd1);
    check_eq("tgt_rec", RecoverPCE, 32'h90);
    step(); ex_idle();
    lookup("newtgt", 32'h100, 1'b1, 32'h90);

    // 0x200 aliases 0x100 and replaces the entry.
    ex_drive(32'h200, BGE, 1'b1, 32'h300, 1'b0, 32'h204, 1'b0);
    step(); ex_idle();
    lookup("alias_old", 32'h100, 1'b0, 32'h104);
    lookup("alias_new", 32'h200, 1'b1, 32'h300);

    // Stalled EX: no mispredict, no training, until release.
    for (int i = 0; i < 3; i++) begin
      ex_drive(32'h40C, BLTU, 1'b1, 32'h500, 1'b0, 32'h410, 1'b1);
      check_eq("stall_mis", {31'd0, MispredictE}, 32'd0);
      step();
      lookup("stall_look", 32'h40C, 1'b0, 32'h410);
    end
    ex_drive(32'h40C, BLTU, 1'b1, 32'h500, 1'b0, 32'h410, 1'b0);
    check_eq("release_mis", {31'd0, MispredictE}, 32'd1);
    step(); ex_idle();
    lookup("release_look", 32'h40C, 1'b1, 32'h500);

    // Non-branch and bubble: never mispredict or train.
    ex_drive(32'h600, NOBRANCH, 1'b1, 32'h700, 1'b0, 32'h604, 1'b0);
    check_eq("nobr_mis", {31'd0, MispredictE}, 32'd0);
    step(); ex_idle();
    lookup("nobr_look", 32'h600, 1'b0, 32'h604);
    ex_drive(32'h604, BEQ, 1'b1, 32'h700, 1'b0, 32'h608, 1'b0);
    ValidE = 1'b0; #1;
    check_eq("bubble_mis", {31'd0, MispredictE}, 32'd0);
    step(); ex_idle();
    lookup("bubble_look", 32'h604, 1'b0, 32'h608);

    // Wraparound of PC+4.
    lookup("wrap_f", 32'hFFFF_FFFC, 1'b0, 32'h0);
    ex_drive(32'hFFFF_FFFC, BGEU, 1'b0, 32'h10, 1'b1, 32'h10, 1'b0);
    check_eq("wrap_mis", {31'd0, MispredictE}, 32'd1);
    check_eq("wrap_rec", RecoverPCE, 32'h0);
    step();
    // Correctly predicted not-taken.
    ex_drive(32'h700, BEQ, 1'b0, 32'h20, 1'b0, 32'h704, 1'b0);
    check_eq("ok_nt_mis", {31'd0, MispredictE}, 32'd0);
    step(); ex_idle();

    // 10 resolved branches, 7 mispredicts so far.
`ifdef BP_STATS_EN
    check_eq("bcnt", BranchCount, 32'd10);
    check_eq("mcnt", MispredictCount, 32'd7);
`else
    check_eq("bcnt_off", BranchCount, 32'd0);
    check_eq("mcnt_off", MispredictCount, 32'd0);
`endif

    CPU_RST = 1'b1;
    step();
    CPU_RST = 1'b0;
    check_eq("post_rst_bcnt", BranchCount, 32'd0);
    check_eq("post_rst_mcnt", MispredictCount, 32'd0);
    lookup("post_rst_200", 32'h200, 1'b0, 32'h204);
    lookup("post_rst_40c", 32'h40C, 1'b0, 32'h410);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
